full_subtractor: RTL and testbench



---
 rtl/full_subtractor.sv | 62 ++++++
 tb/tb_full_subtractor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/full_subtractor.sv
// Single-bit full subtractor with registered diff/borrow and an internal borrow
// register that can replace bin for LSB-first bit-serial subtraction.
module full_subtractor (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic bin,
  input  logic in_valid,
  input  logic chain,
  output logic diff,
  output logic borrow,
  output logic out_valid
);

  // Returns {borrow, diff} for x - y - z.
  function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic z);
    logic d_s;
    logic bo_s;
    d_s  = x ^ y ^ z;
    bo_s = (~x & y) | (~x & z) | (y & z);
    return {bo_s, d_s};
  endfunction

  logic eb_s;
  logic diff_next_s;
  logic borrow_next_s;
  logic diff_r;
  logic borrow_r;
  logic valid_r;

  // Effective borrow-in selection and next-result arithmetic.
  always_comb begin
    eb_s = 1'b0;
    if (chain) begin
      eb_s = borrow_r;
    end else begin
      eb_s = bin;
    end
    {borrow_next_s, diff_next_s} = sub_bit(a, b, eb_s);
  end

  // Result registers; borrow_r doubles as the stored borrow for chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_r   <= 1'b0;
      borrow_r <= 1'b0;
      valid_r  <= 1'b0;
    end else if (in_valid) begin
      diff_r   <= diff_next_s;
      borrow_r <= borrow_next_s;
      valid_r  <= 1'b1;
    end else begin
      valid_r  <= 1'b0;
    end
  end

  assign diff      = diff_r;
  assign borrow    = borrow_r;
  assign out_valid = valid_r;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor: arithmetic reference model feeding a
// scoreboard queue, a truth-table vector array, and hand-written chain sequences.
module tb_full_subtractor;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic bin;
  logic in_valid;
  logic chain;
  logic diff;
  logic borrow;
  logic out_valid;

  typedef struct {
    logic a;
    logic b;
    logic bin;
    logic d;
    logic bo;
  } vec_t;

  typedef struct {
    logic d;
    logic bo;
    logic v;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_d = 1'b0;
  logic m_b = 1'b0;
  logic m_v = 1'b0;

  full_subtractor dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .in_valid (in_valid),
    .chain    (chain),
    .diff     (diff),
    .borrow   (borrow),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic cycle(input logic r, input logic iv, input logic ch,
                       input logic ia, input logic ib, input logic ibin);
    int   res;
    logic eb;
    exp_t e;
    rst = r; in_valid = iv; chain = ch; a = ia; b = ib; bin = ibin;
    if (r) begin
      m_d = 1'b0; m_b = 1'b0; m_v = 1'b0;
    end else if (iv) begin
      eb  = ch ? m_b : ibin;
      res = int'(ia) - int'(ib) - int'(eb);
      m_d = res[0];
      m_b = (res < 0);
      m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
    e.d = m_d; e.bo = m_b; e.v = m_v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("sb_diff", diff, e.d);
      chk("sb_borrow", borrow, e.bo);
      chk("sb_valid", out_valid, e.v);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; chain = 1'b0; a = 1'b0; b = 1'b0; bin = 1'b0;
    @(posedge clk);
    #1;

    // Reset dominates in_valid
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("rst_diff", diff, 1'b0);
      chk("rst_borrow", borrow, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
    end

    // Exhaustive truth table, back to back
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, vecs[i].a, vecs[i].b, vecs[i].bin);
      chk("tt_diff", diff, vecs[i].d);
      chk("tt_borrow", borrow, vecs[i].bo);
      chk("tt_valid", out_valid, 1'b1);
    end

    // Hold on idle with toggling inputs
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, i[0], ~i[0], i[0], ~i[0]);
      chk("hold_diff", diff, 1'b1);
      chk("hold_borrow", borrow, 1'b1);
      chk("hold_valid", out_valid, 1'b0);
    end

    // Bit-serial 0101 - 0110, LSB first, bin=1 ignored when chained
    begin
      logic [3:0] wa;
      logic [3:0] wb;
      wa = 4'b0101;
      wb = 4'b0110;
      cycle(1'b0, 1'b1, 1'b0, wa[0], wb[0], 1'b0);
      chk("ser_diff0", diff, 1'b1);
      for (int i = 1; i < 4; i++) begin
        cycle(1'b0, 1'b1, 1'b1, wa[i], wb[i], 1'b1);
        chk("ser_diff", diff, 1'b1);
      end
      chk("ser_borrow_final", borrow, 1'b1);
    end

    // Chain across an idle gap uses the stored borrow
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap_diff", diff, 1'b0);
    chk("gap_borrow", borrow, 1'b0);

    // Reset mid-chain clears the stored borrow
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_borrow", borrow, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rstchain_diff", diff, 1'b0);
    chk("rstchain_borrow", borrow, 1'b0);
    chk("rstchain_valid", out_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
